// File: rtl/perceptron_trainer.sv
// Trains the two weights of a fixed-threshold two-input perceptron.
// Runs the perceptron learning rule over all four binary patterns until an error-free epoch or the epoch limit.
module perceptron_trainer #(
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned MAX_EPOCHS    = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        target,
   input  logic              v_out,
   output logic              v_in1,
   output logic              v_in2,
   output logic signed [2:0] w1_out,
   output logic signed [2:0] w2_out,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [3:0]        epoch_count
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned W_W   = 3;

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

   state_t                 r_state,    w_state_nxt;
   logic [1:0]             r_p,        w_p_nxt;
   logic                   r_err_flag, w_err_flag_nxt;
   logic [CNT_W-1:0]       r_settle,   w_settle_nxt;
   logic [3:0]             r_target,   w_target_nxt;
   logic signed [W_W-1:0]  r_w1,       w_w1_nxt;
   logic signed [W_W-1:0]  r_w2,       w_w2_nxt;
   logic [CNT_W-1:0]       r_epoch,    w_epoch_nxt;
   logic                   r_busy,     w_busy_nxt;
   logic                   r_done,     w_done_nxt;
   logic                   r_conv,     w_conv_nxt;
   logic                   r_vin1,     w_vin1_nxt;
   logic                   r_vin2,     w_vin2_nxt;

   logic                   w_tbit;
   logic                   w_err_pos;
   logic                   w_err_neg;
   logic                   w_err_any;
   logic                   w_flag_new;
   logic signed [W_W:0]    w_delta;
   logic signed [W_W:0]    w_sum1;
   logic signed [W_W:0]    w_sum2;
   logic [1:0]             w_p_inc;
   logic [CNT_W-1:0]       w_epoch_inc;

   // Clamp a 4-bit signed sum into the 3-bit signed weight range [-4, +3].
   function automatic logic signed [W_W-1:0] sat3(input logic signed [W_W:0] x);
      if (x > 4'sd3)
         return 3'sb011;
      else if (x < 4'sb1100)
         return 3'sb100;
      else
         return x[W_W-1:0];
   endfunction

   assign w_tbit      = r_target[r_p];
   assign w_err_pos   = w_tbit & ~v_out;
   assign w_err_neg   = ~w_tbit & v_out;
   assign w_err_any   = w_err_pos | w_err_neg;
   assign w_flag_new  = r_err_flag | w_err_any;
   assign w_delta     = w_err_pos ? 4'sd1 : (w_err_neg ? 4'sb1111 : 4'sd0);
   assign w_sum1      = 4'(r_w1) + (r_p[1] ? w_delta : 4'sd0);
   assign w_sum2      = 4'(r_w2) + (r_p[0] ? w_delta : 4'sd0);
   assign w_p_inc     = r_p + 2'd1;
   assign w_epoch_inc = (r_epoch == 4'hF) ? 4'hF : r_epoch + 4'd1;

   always_comb begin
      w_state_nxt    = r_state;
      w_p_nxt        = r_p;
      w_err_flag_nxt = r_err_flag;
      w_settle_nxt   = r_settle;
      w_target_nxt   = r_target;
      w_w1_nxt       = r_w1;
      w_w2_nxt       = r_w2;
      w_epoch_nxt    = r_epoch;
      w_busy_nxt     = r_busy;
      w_done_nxt     = r_done;
      w_conv_nxt     = r_conv;
      w_vin1_nxt     = r_vin1;
      w_vin2_nxt     = r_vin2;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt    = S_APPLY;
               w_target_nxt   = target;
               w_w1_nxt       = '0;
               w_w2_nxt       = '0;
               w_epoch_nxt    = '0;
               w_p_nxt        = '0;
               w_err_flag_nxt = 1'b0;
               w_settle_nxt   = '0;
               w_done_nxt     = 1'b0;
               w_conv_nxt     = 1'b0;
               w_busy_nxt     = 1'b1;
               w_vin1_nxt     = 1'b0;
               w_vin2_nxt     = 1'b0;
            end
         end
         S_APPLY: begin
            if (r_settle == CNT_W'(SETTLE_CYCLES - 1)) begin
               w_state_nxt  = S_SAMPLE;
               w_settle_nxt = '0;
            end else begin
               w_settle_nxt = r_settle + CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            if (w_err_any) begin
               w_w1_nxt       = sat3(w_sum1);
               w_w2_nxt       = sat3(w_sum2);
               w_err_flag_nxt = 1'b1;
            end
            if (r_p != 2'd3) begin
               w_p_nxt     = w_p_inc;
               w_state_nxt = S_APPLY;
               w_vin1_nxt  = w_p_inc[1];
               w_vin2_nxt  = w_p_inc[0];
            end else begin
               w_epoch_nxt = w_epoch_inc;
               w_vin1_nxt  = 1'b0;
               w_vin2_nxt  = 1'b0;
               if (!w_flag_new || (w_epoch_inc == CNT_W'(MAX_EPOCHS))) begin
                  w_state_nxt = S_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_conv_nxt  = !w_flag_new;
               end else begin
                  w_err_flag_nxt = 1'b0;
                  w_p_nxt        = '0;
                  w_state_nxt    = S_APPLY;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_p        <= '0;
         r_err_flag <= 1'b0;
         r_settle   <= '0;
         r_target   <= '0;
         r_w1       <= '0;
         r_w2       <= '0;
         r_epoch    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_conv     <= 1'b0;
         r_vin1     <= 1'b0;
         r_vin2     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_p        <= w_p_nxt;
         r_err_flag <= w_err_flag_nxt;
         r_settle   <= w_settle_nxt;
         r_target   <= w_target_nxt;
         r_w1       <= w_w1_nxt;
         r_w2       <= w_w2_nxt;
         r_epoch    <= w_epoch_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_conv     <= w_conv_nxt;
         r_vin1     <= w_vin1_nxt;
         r_vin2     <= w_vin2_nxt;
      end
   end

   assign v_in1       = r_vin1;
   assign v_in2       = r_vin2;
   assign w1_out      = r_w1;
   assign w2_out      = r_w2;
   assign busy        = r_busy;
   assign done        = r_done;
   assign converged   = r_conv;
   assign epoch_count = r_epoch;

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Training controller that sits on the input side of the two-input perceptron and drives its `v_in1`/`v_in2`/`w1_in`/`w2_in` ports. On `start` it runs the classic perceptron learning rule over all four binary input patterns, epoch by epoch. It samples the perceptron's `v_out`, compares it against a 4-bit target truth table, and adjusts the two signed 3-bit weights. It stops when one full epoch produces no errors (converged) or when an epoch limit is reached (failed). The perceptron's threshold/bias is fixed inside the perceptron and is not trained.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 3: cycles each pattern is held before `v_out` is sampled. Legal range 2..15, because the perceptron needs 2 clock edges before `v_out` reflects new inputs and weights.
- `MAX_EPOCHS`, default 15: epoch limit. Legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin training; sampled only in IDLE or DONE.
- `target`  in  4  truth table; `target[p]` is the desired output for pattern p = {v_in1, v_in2}; latched on accepted `start`.
- `v_out`  in  1  perceptron output.
- `v_in1`  out  1  pattern bit 1 to perceptron.
- `v_in2`  out  1  pattern bit 0 to perceptron.
- `w1_out`  out  3 signed  weight 1 to perceptron `w1_in`.
- `w2_out`  out  3 signed  weight 2 to perceptron `w2_in`.
- `busy`  out  1  high in APPLY/SAMPLE.
- `done`  out  1  level; high in DONE until the next accepted `start` or `reset`.
- `converged`  out  1  valid while `done`; 1 means an error-free epoch was reached.
- `epoch_count`  out  4  number of completed epochs.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- Reset values: state IDLE; `v_in1`, `v_in2`, `w1_out`, `w2_out`, `busy`, `done`, `converged` all 0; `epoch_count` 0; pattern index 0; error flag 0; settle counter 0.
- IDLE/DONE with `start`=1 → APPLY. The same edge latches `target` and clears weights to 0, `epoch_count` to 0, pattern index p to 0, error flag, `done` and `converged`.
- APPLY: drive `v_in1`=p[1] and `v_in2`=p[0] and count `SETTLE_CYCLES` cycles. On the last one → SAMPLE.
- SAMPLE (1 cycle): err = `target[p]` − `v_out`, with value in {−1, 0, +1}.
  - If err≠0: w1 += err·p[1] and w2 += err·p[0], each saturating to [−4, +3]; set the error flag.
  - If p<3: p++ → APPLY.
  - If p=3: `epoch_count`++ (saturating at 15), then:
    - If no error occurred this epoch (including this sample) → DONE with `converged`=1.
    - Else if the new count equals `MAX_EPOCHS` → DONE with `converged`=0.
    - Else clear the error flag, set p=0 → APPLY.
- Weight arithmetic: compute in at least 4-bit signed, then clamp. +3+1 stays +3; −4−1 stays −4.
- DONE: `v_in*` return to 0; weights and `epoch_count` hold their final values.
- `start` during APPLY/SAMPLE is ignored.
- `reset` takes priority over `start` in the same cycle. `reset` mid-training returns all outputs to reset values on that edge.

## Timing
- Accepted `start` at edge k: `busy`=1 and pattern 00 driven from edge k+1.
- Each pattern occupies `SETTLE_CYCLES`+1 cycles. An epoch takes 4·(`SETTLE_CYCLES`+1) cycles, which is 16 at the default.
- Weight updates become visible on `w*_out` at the edge that ends SAMPLE. The next pattern's APPLY begins at that same edge.
- `done` rises, and `busy` falls, on the edge ending the final SAMPLE.
- `v_out` is sampled only during SAMPLE; its value in other cycles is don't-care.

## Test plan
- Reset: assert `reset` for 2 cycles mid-training → all outputs read 0 and state is IDLE on the next cycle.
- Connected to the perceptron, `target`=4'b1111, `start` → `converged`=1, `epoch_count`=1, w1=w2=0; `done` rises 16 cycles after `busy` rises.
- Connected, `target`=4'b0001 (NOR) → `converged`=1, `epoch_count`=3, w1=w2=−3. Expected weight trace at end of epochs 1 and 2: −2/−2, then −3/−3.
- Connected, `target`=4'b1000 (AND): pattern 00 is never correctable → `converged`=0, `epoch_count`=15, `done`=1.
- Standalone, bench forces `v_out`=0 with `target`=4'b1111 → weights reach +3/+3 in epoch 2 and stay saturated at +3 with no wrap; `converged`=0 after `MAX_EPOCHS`.
- `start` pulsed while `busy` → ignored, and `target` is not relatched. `start` coincident with `reset` → remains IDLE.
